clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 124 ++++++++++++
 tb/tb_clk_div_prog.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider.
// Each channel divides clk by a divisor D with a programmable high time H.
// New D/H values are queued per channel and take effect only at the end of
// the running period, or at once on a sync pulse, so no runt pulses occur.
//
// Config handshake: a request transfers on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready depends only on the addressed channel's
// pending flag and is independent of cfg_valid. A requester that sees
// cfg_ready low keeps cfg_valid, cfg_ch, cfg_div and cfg_high stable until
// cfg_ready rises. Channel indices at or above NCH read as ready and the
// request is dropped.
module clk_div_prog #(
  parameter int NCH      = 2,
  parameter int W        = 8,
  parameter int DEF_DIV  = 4,
  parameter int DEF_HIGH = 2,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic [W-1:0]   cfg_high,
  output logic           cfg_ready,
  input  logic           sync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  // Pending flags of all channels, gathered for the ready mux.
  logic [NCH-1:0] pend_vec;
  logic           sel_pend;

  // Select the pending flag of the addressed channel; out-of-range reads 0.
  always_comb begin
    sel_pend = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_ch == CHW'(c)) sel_pend = pend_vec[c];
    end
  end

  assign cfg_ready = !sel_pend;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0] div_q,   div_d;
    logic [W-1:0] high_q,  high_d;
    logic [W-1:0] cnt_q,   cnt_d;
    logic [W-1:0] pdiv_q,  pdiv_d;
    logic [W-1:0] phigh_q, phigh_d;
    logic         pend_q,  pend_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q,    tick_d;
    logic         en;
    logic         wrap;
    logic         acc;

    assign en   = (div_q != '0);
    assign wrap = en && (cnt_q == div_q - W'(1));
    assign acc  = cfg_valid && (cfg_ch == CHW'(c)) && !pend_q;

    // Next-state: count, apply queued config at period end or on sync,
    // otherwise queue an accepted request.
    always_comb begin
      div_d     = div_q;
      high_d    = high_q;
      pdiv_d    = pdiv_q;
      phigh_d   = phigh_q;
      pend_d    = pend_q;
      cnt_d     = (en && !wrap) ? cnt_q + W'(1) : '0;
      clk_out_d = en && (cnt_q < high_q);
      tick_d    = wrap;
      if (sync) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = pdiv_q;
          high_d = phigh_q;
          pend_d = 1'b0;
        end else if (acc) begin
          // Same-cycle sync and accept: new values go live directly.
          div_d  = cfg_div;
          high_d = cfg_high;
        end
      end else if (pend_q && (wrap || !en)) begin
        div_d  = pdiv_q;
        high_d = phigh_q;
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (acc) begin
        pdiv_d  = cfg_div;
        phigh_d = cfg_high;
        pend_d  = 1'b1;
      end
    end

    // Channel state register with synchronous reset to the defaults.
    always_ff @(posedge clk) begin
      if (reset) begin
        div_q     <= W'(DEF_DIV);
        high_q    <= W'(DEF_HIGH);
        cnt_q     <= '0;
        pdiv_q    <= '0;
        phigh_q   <= '0;
        pend_q    <= 1'b0;
        clk_out_q <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        div_q     <= div_d;
        high_q    <= high_d;
        cnt_q     <= cnt_d;
        pdiv_q    <= pdiv_d;
        phigh_q   <= phigh_d;
        pend_q    <= pend_d;
        clk_out_q <= clk_out_d;
        tick_q    <= tick_d;
      end
    end

    assign pend_vec[c] = pend_q;
    assign clk_out[c]  = clk_out_q;
    assign tick[c]     = tick_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog (NCH=2, W=8, DEF_DIV=4, DEF_HIGH=2).
// Bus values are {ch1, ch0}.
module tb_clk_div_prog;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_ready;
  logic       sync;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int checks;
  int errors;

  // Expected tables
  logic [1:0] def_clk  [8]  = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
  logic [1:0] def_tick [8]  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
  logic [1:0] p2_clk   [6]  = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b10};
  logic [1:0] p2_tick  [6]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [1:0] p3_clk   [4]  = '{2'b10, 2'b01, 2'b01, 2'b11};
  logic [1:0] p3_tick  [4]  = '{2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] sk_clk   [15] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10,
                                2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10};
  logic [1:0] sk_tick  [15] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01,
                                2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
  logic [1:0] sw_clk   [4]  = '{2'b00, 2'b11, 2'b11, 2'b10};
  logic [1:0] sw_tick  [4]  = '{2'b01, 2'b00, 2'b00, 2'b00};

  clk_div_prog #(
    .NCH(2), .W(8), .DEF_DIV(4), .DEF_HIGH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_ready(cfg_ready),
    .sync     (sync),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic v, input logic ch, input logic [7:0] d, input logic [7:0] h);
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_high  = h;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    sync  = 1'b0;
    cfg(1'b0, 1'b0, 8'd0, 8'd0);

    // Reset state
    step();
    step();
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h1);

    // Default divide-by-4, high 2
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("def_clk[%0d]", k), 32'(clk_out), 32'(def_clk[k]));
      check($sformatf("def_tick[%0d]", k), 32'(tick), 32'(def_tick[k]));
    end

    // Mid-period reconfig of ch0 to D=6 H=3
    step();
    cfg(1'b1, 1'b0, 8'd6, 8'd3);
    #1;
    check("p2_ready_idle", 32'(cfg_ready), 32'h1);
    step();
    check("p2_clk_acc", 32'(clk_out), 32'h3);
    // Held request while busy must be ignored
    cfg(1'b1, 1'b0, 8'd7, 8'd7);
    #1;
    check("p2_ready_busy", 32'(cfg_ready), 32'h0);
    step();
    check("p2_clk_mid", 32'(clk_out), 32'h0);
    check("p2_ready_busy2", 32'(cfg_ready), 32'h0);
    cfg(1'b0, 1'b0, 8'd0, 8'd0);
    step();
    check("p2_clk_end", 32'(clk_out), 32'h0);
    check("p2_tick_end", 32'(tick), 32'h3);
    check("p2_ready_after", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("p2_clk[%0d]", k), 32'(clk_out), 32'(p2_clk[k]));
      check($sformatf("p2_tick[%0d]", k), 32'(tick), 32'(p2_tick[k]));
    end

    // Disable ch1, then re-enable with D=3 H=1
    cfg(1'b1, 1'b1, 8'd0, 8'd0);
    #1;
    check("p3_ready1", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    check("p3_clk_a", 32'(clk_out), 32'h1);
    check("p3_tick_a", 32'(tick), 32'h0);
    #1;
    check("p3_ready_pend", 32'(cfg_ready), 32'h0);
    step();
    check("p3_clk_b", 32'(clk_out), 32'h1);
    check("p3_tick_b", 32'(tick), 32'h2);
    step();
    check("p3_clk_dis", 32'(clk_out), 32'h1);
    check("p3_tick_dis", 32'(tick), 32'h0);
    cfg(1'b1, 1'b1, 8'd3, 8'd1);
    #1;
    check("p3_ready2", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    check("p3_clk_c", 32'(clk_out), 32'h0);
    #1;
    check("p3_ready_pend2", 32'(cfg_ready), 32'h0);
    step();
    check("p3_clk_d", 32'(clk_out), 32'h0);
    check("p3_tick_d", 32'(tick), 32'h0);
    check("p3_ready_applied", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("p3_clk[%0d]", k), 32'(clk_out), 32'(p3_clk[k]));
      check($sformatf("p3_tick[%0d]", k), 32'(tick), 32'(p3_tick[k]));
    end

    // Boundaries: ch0 D=1 H=1, ch1 D=5 H=0 via sync
    reset = 1'b1;
    step();
    step();
    check("rst2_clk_out", 32'(clk_out), 32'h0);
    check("rst2_ready", 32'(cfg_ready), 32'h1);
    reset = 1'b0;
    cfg(1'b1, 1'b0, 8'd1, 8'd1);
    step();
    check("b_clk_f1", 32'(clk_out), 32'h3);
    cfg(1'b1, 1'b1, 8'd5, 8'd0);
    sync = 1'b1;
    #1;
    check("b_ready_ch1", 32'(cfg_ready), 32'h1);
    step();
    check("b_clk_f2", 32'(clk_out), 32'h3);
    check("b_tick_f2", 32'(tick), 32'h0);
    cfg_valid = 1'b0;
    sync = 1'b0;
    #1;
    check("b_ready_ch1_nopend", 32'(cfg_ready), 32'h1);
    cfg_ch = 1'b0;
    #1;
    check("b_ready_ch0_cleared", 32'(cfg_ready), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("b_clk[%0d]", i), 32'(clk_out), 32'h1);
      check($sformatf("b_tick[%0d]", i), 32'(tick), (i == 4 || i == 9) ? 32'h3 : 32'h1);
    end
    // ch1 D=5 H=9 -> constant high
    cfg(1'b1, 1'b1, 8'd5, 8'd9);
    sync = 1'b1;
    step();
    check("b2_clk", 32'(clk_out), 32'h1);
    check("b2_tick", 32'(tick), 32'h1);
    cfg_valid = 1'b0;
    sync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("b2_clk[%0d]", i), 32'(clk_out), 32'h3);
      check($sformatf("b2_tick[%0d]", i), 32'(tick), (i == 4) ? 32'h3 : 32'h1);
    end

    // Skewed ch0 D=4 H=2 and ch1 D=6 H=3, then sync
    cfg(1'b1, 1'b0, 8'd4, 8'd2);
    step();
    cfg(1'b1, 1'b1, 8'd6, 8'd3);
    step();
    cfg_valid = 1'b0;
    step();
    step();
    step();
    step();
    check("sk_clk_pre", 32'(clk_out), 32'h2);
    check("sk_tick_pre", 32'(tick), 32'h1);
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sk_clk_sync", 32'(clk_out), 32'h3);
    check("sk_tick_sync", 32'(tick), 32'h0);
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("sk_clk[%0d]", k), 32'(clk_out), 32'(sk_clk[k]));
      check($sformatf("sk_tick[%0d]", k), 32'(tick), 32'(sk_tick[k]));
    end
    // Sync coinciding with ch0 natural wrap
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sw_clk[0]", 32'(clk_out), 32'(sw_clk[0]));
    check("sw_tick[0]", 32'(tick), 32'(sw_tick[0]));
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("sw_clk[%0d]", k), 32'(clk_out), 32'(sw_clk[k]));
      check($sformatf("sw_tick[%0d]", k), 32'(tick), 32'(sw_tick[k]));
    end

    // Reset with pending ch0 config, sync and cfg_valid asserted
    cfg(1'b1, 1'b0, 8'd9, 8'd9);
    step();
    #1;
    check("r_ready_pend", 32'(cfg_ready), 32'h0);
    reset = 1'b1;
    sync  = 1'b1;
    step();
    check("r_clk_out", 32'(clk_out), 32'h0);
    check("r_tick", 32'(tick), 32'h0);
    check("r_ready", 32'(cfg_ready), 32'h1);
    reset = 1'b0;
    sync  = 1'b0;
    cfg_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("r_clk[%0d]", k), 32'(clk_out), 32'(def_clk[k]));
      check($sformatf("r_tick[%0d]", k), 32'(tick), 32'(def_tick[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
